// File: rtl/i2c_hub_pkg.sv
// Shared definitions for the multi-channel I2C hub: FSM encoding, command header
// field positions and STATUS bit layout.
package i2c_hub_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_MASK  = 4'd1,
    S_HDR   = 4'd2,
    S_ADDR  = 4'd3,
    S_DATA  = 4'd4,
    S_EXEC  = 4'd5,
    S_WAIT  = 4'd6,
    S_ABORT = 4'd7,
    S_DONE  = 4'd8
  } hub_state_e;

  localparam int HDR_N_MSB = 7;
  localparam int HDR_N_LSB = 4;
  localparam int HDR_RD    = 3;

  localparam int ST_ROVF = 7;
  localparam int ST_WOVF = 6;
  localparam int ST_TMO  = 5;
  localparam int ST_NACK = 4;

  // Engines need a couple of cycles after EXECUTE before CH_READY drops.
  localparam int GUARD_CYC = 2;

endpackage

// File: rtl/i2c_hub_fifo.sv
// Synchronous first-word-fall-through byte FIFO with single-cycle flush and a
// sticky overflow flag (set when a push is dropped).
module i2c_hub_fifo #(
  parameter int DEPTH = 32
) (
  input  logic       CLK40,
  input  logic       rst_fifo,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [7:0] o_dout,
  output logic       o_empty,
  output logic       o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_full, w_do_push, w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign o_dout    = o_empty ? 8'h00 : r_mem[r_rp];
  assign o_ovf     = r_ovf;

  always_ff @(posedge CLK40) begin
    if (w_do_push && !i_flush) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_push && w_full && !i_pop) r_ovf <= 1'b1;
      if (i_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_do_push) r_wp <= r_wp + AW'(1);
        if (w_do_pop)  r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
      end
    end
  end

endmodule

// File: rtl/i2c_multi_chan_hub.sv
// JTAG-side command parser driving N_CH I2C engines over a shared load/execute bus;
// writes broadcast to the mask, reads run one channel at a time, lowest index first.
module i2c_multi_chan_hub
  import i2c_hub_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int WFIFO_DEPTH = 32,
  parameter int RFIFO_DEPTH = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              CLK40,
  input  logic              rst_fifo,
  input  logic [7:0]        WDATA,
  input  logic              WE,
  input  logic              START,
  input  logic              RDENA,
  output logic [7:0]        RBK_DATA,
  output logic              RBK_EMPTY,
  output logic              CLR_START,
  output logic [7:0]        STATUS,
  output logic [N_CH-1:0]   NACK_FLG,
  output logic [N_CH-1:0]   CH_SEL,
  output logic              LOAD_N_BYTE,
  output logic              LOAD_ADDR,
  output logic [3:0]        WRT_ADDR,
  output logic [7:0]        WRT_DATA,
  output logic              WRT_ENA,
  output logic              EXECUTE,
  input  logic [N_CH-1:0]   CH_READY,
  input  logic [N_CH-1:0]   CH_RBK_WE,
  input  logic [8*N_CH-1:0] CH_RBK_DATA,
  input  logic [N_CH-1:0]   CH_NACK
);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1) + 1;

  hub_state_e      r_st, w_nx;
  logic [N_CH-1:0] r_mask, r_pend, r_nack, w_act, w_sel;
  logic [3:0]      r_n, r_widx;
  logic            r_rd, r_tmo;
  logic [WDW-1:0]  r_wd;
  logic [7:0]      w_whead, w_rdat;
  logic            w_wempty, w_wovf, w_rovf, w_pop, w_flush;
  logic            w_done, w_tmo_hit, w_rpush, w_load;

  i2c_hub_fifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
    .CLK40(CLK40), .rst_fifo(rst_fifo), .i_push(WE), .i_din(WDATA),
    .i_pop(w_pop), .i_flush(w_flush), .o_dout(w_whead), .o_empty(w_wempty), .o_ovf(w_wovf)
  );

  i2c_hub_fifo #(.DEPTH(RFIFO_DEPTH)) u_rfifo (
    .CLK40(CLK40), .rst_fifo(rst_fifo), .i_push(w_rpush), .i_din(w_rdat),
    .i_pop(RDENA), .i_flush(1'b0), .o_dout(RBK_DATA), .o_empty(RBK_EMPTY), .o_ovf(w_rovf)
  );

  // Lowest pending channel as a one-hot vector.
  assign w_act     = r_pend & (~r_pend + N_CH'(1));
  assign w_load    = (r_st inside {S_HDR, S_ADDR, S_DATA}) && !w_wempty;
  assign w_done    = (r_wd >= WDW'(GUARD_CYC)) && (&(CH_READY | ~w_sel));
  assign w_tmo_hit = (r_wd >= WDW'(TIMEOUT_CYC));
  assign w_rpush   = (r_st == S_WAIT) && r_rd && (|(CH_RBK_WE & w_act));

  always_comb begin
    w_rdat = 8'h00;
    for (int i = 0; i < N_CH; i++)
      if (w_act[i]) w_rdat = CH_RBK_DATA[8*i +: 8];
  end

  always_comb begin
    w_sel = '0;
    case (r_st)
      S_HDR, S_ADDR, S_DATA: w_sel = r_mask;
      S_EXEC, S_WAIT:        w_sel = r_rd ? w_act : r_mask;
      default:               w_sel = '0;
    endcase
  end

  always_comb begin
    w_nx    = r_st;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    case (r_st)
      S_IDLE: if (START) w_nx = w_wempty ? S_DONE : S_MASK;
      S_MASK:
        if (w_wempty) w_nx = S_ABORT;
        else begin
          w_pop = 1'b1;
          w_nx  = (w_whead[N_CH-1:0] == '0) ? S_ABORT : S_HDR;
        end
      S_HDR:
        if (w_wempty) w_nx = S_ABORT;
        else begin
          w_pop = 1'b1;
          w_nx  = S_ADDR;
        end
      S_ADDR:
        if (w_wempty) w_nx = S_ABORT;
        else begin
          w_pop = 1'b1;
          w_nx  = (r_rd || r_n == 4'd0) ? S_EXEC : S_DATA;
        end
      S_DATA:
        if (w_wempty) w_nx = S_ABORT;
        else begin
          w_pop = 1'b1;
          w_nx  = (r_widx == r_n - 4'd1) ? S_EXEC : S_DATA;
        end
      S_EXEC: w_nx = S_WAIT;
      S_WAIT:
        if (w_done) begin
          if (r_rd && ((r_pend & ~w_act) != '0)) w_nx = S_EXEC;
          else w_nx = w_wempty ? S_DONE : S_MASK;
        end else if (w_tmo_hit) w_nx = S_ABORT;
      S_ABORT: begin
        w_flush = 1'b1;
        w_nx    = S_DONE;
      end
      S_DONE: if (!START) w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or posedge rst_fifo) begin
    if (rst_fifo) begin
      r_st   <= S_IDLE;
      r_mask <= '0;
      r_pend <= '0;
      r_nack <= '0;
      r_n    <= '0;
      r_widx <= '0;
      r_rd   <= 1'b0;
      r_tmo  <= 1'b0;
      r_wd   <= '0;
    end else begin
      r_st <= w_nx;
      case (r_st)
        S_IDLE:
          if (START && !w_wempty) begin
            r_tmo  <= 1'b0;
            r_nack <= '0;
          end
        S_MASK:
          if (!w_wempty) begin
            r_mask <= w_whead[N_CH-1:0];
            r_pend <= w_whead[N_CH-1:0];
          end
        S_HDR:
          if (!w_wempty) begin
            r_n  <= w_whead[HDR_N_MSB:HDR_N_LSB];
            r_rd <= w_whead[HDR_RD];
          end
        S_ADDR: r_widx <= '0;
        S_DATA: if (!w_wempty) r_widx <= r_widx + 4'd1;
        S_EXEC: r_wd <= '0;
        S_WAIT: begin
          r_wd   <= r_wd + WDW'(1);
          r_nack <= r_nack | (CH_NACK & w_sel);
          if (w_done) begin
            if (r_rd) r_pend <= r_pend & ~w_act;
          end else if (w_tmo_hit) r_tmo <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign CH_SEL      = w_sel;
  assign LOAD_N_BYTE = (r_st == S_HDR) && !w_wempty;
  assign LOAD_ADDR   = (r_st == S_ADDR) && !w_wempty;
  assign WRT_ENA     = (r_st == S_DATA) && !w_wempty;
  assign WRT_DATA    = w_load ? w_whead : 8'h00;
  assign WRT_ADDR    = r_widx;
  assign EXECUTE     = (r_st == S_EXEC);
  assign CLR_START   = (r_st == S_DONE) && START;
  assign NACK_FLG    = r_nack;
  assign STATUS      = {w_rovf, w_wovf, r_tmo, |r_nack, r_st};

endmodule
